// File: rtl/orange_c_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// orange_c_sweep_ctrl_if
// Groups the signals that connect the sweep controller to the system
// controller and to the Orange_c instance under test.
//   start          request a sweep (system controller -> sweep ctrl)
//   a,b,c,d        stimulus vector to Orange_c, {a,b,c,d} = index
//   y,z            Orange_c outputs fed back to the sweep ctrl
//   busy,done      sweep status
//   pass           last sweep had no mismatches
//   err_count      number of mismatching vectors in the last sweep
//   first_err_idx  index of the first mismatching vector
// Modports:
//   slave   the sweep controller itself
//   master  everything around it (system controller plus the Orange_c side)
// ---------------------------------------------------------------------------
interface orange_c_sweep_ctrl_if;
  logic       start;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic       y;
  logic       z;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic [3:0] first_err_idx;

  modport slave (
    input  start, y, z,
    output a, b, c, d, busy, done, pass, err_count, first_err_idx
  );

  modport master (
    output start, y, z,
    input  a, b, c, d, busy, done, pass, err_count, first_err_idx
  );
endinterface

// File: rtl/orange_c_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// orange_c_sweep_ctrl
// Self-checking sequencer for one Orange_c 4-input/2-output logic block.
// A start request walks {a,b,c,d} through all 16 codes, lets each code settle
// for HOLD_CYCLES cycles, then compares y/z against the expected truth tables
// EXP_Y/EXP_Z (bit i = output for input code i, a is the MSB of i).
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high
//   bus   orange_c_sweep_ctrl_if.slave: start, y, z in;
//         a..d, busy, done, pass, err_count, first_err_idx out
//
// Optional feature macro: ORANGE_C_SWEEP_STOP_ON_ERR_EN
//   When defined, the first mismatching vector ends the sweep immediately.
//   When undefined, all 16 vectors are always checked and counted.
// ---------------------------------------------------------------------------
module orange_c_sweep_ctrl #(
  parameter int          HOLD_CYCLES = 1,
  parameter logic [15:0] EXP_Y       = 16'h0000,
  parameter logic [15:0] EXP_Z       = 16'h0000
) (
  input logic                   clk,
  input logic                   rst,
  orange_c_sweep_ctrl_if.slave  bus
);

  // Counter only needs to reach HOLD_CYCLES-1.
  localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CHECK,
    DONE
  } state_t;

  state_t        state;
  logic [3:0]    idx;
  logic [3:0]    stim;
  logic [HW-1:0] hold_cnt;
  logic          busy_q;
  logic          done_q;
  logic          pass_q;
  logic [4:0]    err_q;
  logic [3:0]    first_q;
  logic          mismatch;

  assign mismatch = (bus.y != EXP_Y[idx]) || (bus.z != EXP_Z[idx]);

  assign bus.a             = stim[3];
  assign bus.b             = stim[2];
  assign bus.c             = stim[1];
  assign bus.d             = stim[0];
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_idx = first_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 4'd0;
      stim     <= 4'd0;
      hold_cnt <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 5'd0;
      first_q  <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            idx      <= 4'd0;
            stim     <= 4'd0;
            hold_cnt <= '0;
            err_q    <= 5'd0;
            pass_q   <= 1'b0;
            first_q  <= 4'd0;
            busy_q   <= 1'b1;
            state    <= WAIT;
          end
        end

        WAIT: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) begin
            state <= CHECK;
          end
        end

        CHECK: begin
          if (mismatch) begin
            err_q <= err_q + 5'd1;
            if (err_q == 5'd0) begin
              first_q <= idx;
            end
          end
`ifdef ORANGE_C_SWEEP_STOP_ON_ERR_EN
          if (mismatch || (idx == 4'd15)) begin
`else
          if (idx == 4'd15) begin
`endif
            // Stimulus is left on the last applied vector.
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= DONE;
          end else begin
            idx      <= idx + 4'd1;
            stim     <= idx + 4'd1;
            hold_cnt <= '0;
            state    <= WAIT;
          end
        end

        DONE: begin
          pass_q <= (err_q == 5'd0);
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_orange_c_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_orange_c_sweep_ctrl
// Bench for orange_c_sweep_ctrl with an Orange_c stand-in y=a&b, z=c|d.
// Faults are injected into y per input code through the flip mask.
// Two instances: HOLD_CYCLES=1 and HOLD_CYCLES=3, selected by sel.
// ---------------------------------------------------------------------------
module tb_orange_c_sweep_ctrl;

  typedef struct {
    int err;
    int first;
    int pass;
    int done_edge;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_drv;
  logic        sel;
  logic [15:0] flip;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  orange_c_sweep_ctrl_if bus1 ();
  orange_c_sweep_ctrl_if bus3 ();

  // Orange_c stand-in models with per-code fault injection on y.
  assign bus1.start = start_drv & ~sel;
  assign bus1.y     = (bus1.a & bus1.b) ^ flip[{bus1.a, bus1.b, bus1.c, bus1.d}];
  assign bus1.z     = bus1.c | bus1.d;
  assign bus3.start = start_drv & sel;
  assign bus3.y     = (bus3.a & bus3.b) ^ flip[{bus3.a, bus3.b, bus3.c, bus3.d}];
  assign bus3.z     = bus3.c | bus3.d;

  orange_c_sweep_ctrl #(
    .HOLD_CYCLES (1),
    .EXP_Y       (16'hF000),
    .EXP_Z       (16'hEEEE)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  orange_c_sweep_ctrl #(
    .HOLD_CYCLES (3),
    .EXP_Y       (16'hF000),
    .EXP_Z       (16'hEEEE)
  ) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  logic [3:0] obs_abcd;
  logic       obs_busy;
  logic       obs_done;
  logic       obs_pass;
  logic [4:0] obs_err;
  logic [3:0] obs_first;

  always_comb begin
    obs_abcd  = sel ? {bus3.a, bus3.b, bus3.c, bus3.d} : {bus1.a, bus1.b, bus1.c, bus1.d};
    obs_busy  = sel ? bus3.busy : bus1.busy;
    obs_done  = sel ? bus3.done : bus1.done;
    obs_pass  = sel ? bus3.pass : bus1.pass;
    obs_err   = sel ? bus3.err_count : bus1.err_count;
    obs_first = sel ? bus3.first_err_idx : bus1.first_err_idx;
  end

  task automatic checkOutput(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // One sweep: compute the expected result, push it, pulse start, follow the
  // sweep edge by edge and pop the expectation when done appears.
  // poke re-asserts start at edges 10..14; abort_edge>0 applies rst there.
  task automatic applyStimulus(input logic [15:0] f, input bit poke,
                               input int abort_edge, input bit use3);
    exp_t e;
    exp_t got_e;
    int   h;
    int   cnt;
    int   last_idx;
    int   want_idx;
    int   limit;
    int   dones;
    bit   seen;

    sel   = use3;
    flip  = f;
    h     = use3 ? 3 : 1;
    cnt   = 0;
    e.first = 0;
    for (int i = 0; i < 16; i++) begin
      if (f[i]) begin
        if (cnt == 0) e.first = i;
        cnt++;
      end
    end
`ifdef ORANGE_C_SWEEP_STOP_ON_ERR_EN
    if (cnt > 0) begin
      e.err       = 1;
      e.done_edge = (e.first + 1) * (h + 1);
      last_idx    = e.first;
    end else begin
      e.err       = 0;
      e.done_edge = 16 * (h + 1);
      last_idx    = 15;
    end
`else
    e.err       = cnt;
    e.done_edge = 16 * (h + 1);
    last_idx    = 15;
`endif
    e.pass = (e.err == 0) ? 1 : 0;
    if (abort_edge == 0) sb.push_back(e);

    @(negedge clk);
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    checkOutput("busy_after_start", int'(obs_busy), 1);
    checkOutput("abcd_after_start", int'(obs_abcd), 0);

    seen  = 1'b0;
    limit = 16 * (h + 1) + 20;
    for (int k = 1; k <= limit && !seen; k++) begin
      start_drv = poke && (k >= 10) && (k <= 14);
      rst       = (k == abort_edge);
      @(negedge clk);
      if (k == abort_edge) begin
        rst       = 1'b0;
        start_drv = 1'b0;
        checkOutput("abort_busy", int'(obs_busy), 0);
        checkOutput("abort_abcd", int'(obs_abcd), 0);
        checkOutput("abort_err", int'(obs_err), 0);
        checkOutput("abort_done", int'(obs_done), 0);
        dones = 0;
        for (int j = 0; j < 40; j++) begin
          @(negedge clk);
          if (obs_done) dones++;
        end
        checkOutput("abort_no_done", dones, 0);
        return;
      end
      if ((k % (h + 1)) == 0 && k <= e.done_edge) begin
        want_idx = k / (h + 1);
        if (want_idx > last_idx) want_idx = last_idx;
        checkOutput("abcd_step", int'(obs_abcd), want_idx);
      end
      if (obs_done) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          checkOutput("sb_empty_on_done", 0, 1);
        end else begin
          got_e = sb.pop_front();
          checkOutput("done_edge", k, got_e.done_edge);
          checkOutput("err_count", int'(obs_err), got_e.err);
          if (got_e.err != 0) checkOutput("first_err_idx", int'(obs_first), got_e.first);
          checkOutput("busy_at_done", int'(obs_busy), 0);
          checkOutput("abcd_at_done", int'(obs_abcd), last_idx);
          start_drv = 1'b0;
          @(negedge clk);
          checkOutput("done_one_cycle", int'(obs_done), 0);
          checkOutput("pass", int'(obs_pass), got_e.pass);
          repeat (5) @(negedge clk);
          checkOutput("pass_held", int'(obs_pass), got_e.pass);
        end
      end
    end
    start_drv = 1'b0;
    if (!seen) checkOutput("done_timeout", 0, 1);
  endtask

  initial begin
    rst       = 1'b1;
    start_drv = 1'b0;
    sel       = 1'b0;
    flip      = 16'h0000;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", int'(obs_busy), 0);
    checkOutput("rst_done", int'(obs_done), 0);
    checkOutput("rst_pass", int'(obs_pass), 0);
    checkOutput("rst_err", int'(obs_err), 0);
    checkOutput("rst_first", int'(obs_first), 0);
    checkOutput("rst_abcd", int'(obs_abcd), 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] clean sweep");
    applyStimulus(16'h0000, 1'b0, 0, 1'b0);
    $display("[TB] y wrong at idx 5 and 9");
    applyStimulus(16'h0220, 1'b0, 0, 1'b0);
    $display("[TB] start poked mid-sweep");
    applyStimulus(16'h0000, 1'b1, 0, 1'b0);
    $display("[TB] reset at edge 12, then fresh sweep");
    applyStimulus(16'h0000, 1'b0, 12, 1'b0);
    applyStimulus(16'h0000, 1'b0, 0, 1'b0);
    $display("[TB] HOLD_CYCLES=3 instance");
    applyStimulus(16'h0000, 1'b0, 0, 1'b1);
    $display("[TB] single error at idx 5");
    applyStimulus(16'h0020, 1'b0, 0, 1'b0);
    $display("[TB] errors at idx 0 and 15");
    applyStimulus(16'h8001, 1'b0, 0, 1'b0);

    checkOutput("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
